// File: rtl/rs_station.sv
// Reservation station: issue with tagged/ready operands, CDB wakeup, one valid/ready dispatch per cycle.
// Optional macro RS_AGE_SELECT_EN: dispatch the oldest ready entry (age matrix) instead of the lowest index.
module rs_station #(
  parameter int               DEPTH     = 8,
  parameter int               WORD_W    = 32,
  parameter int               TAG_W     = 8,
  parameter logic [TAG_W-1:0] UNIT_BASE = 8'h20,
  parameter logic [TAG_W-1:0] READY_TAG = 8'h7F,
  parameter int               OP_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [WORD_W-1:0]          issue_vj,
  input  logic [TAG_W-1:0]           issue_qk,
  input  logic [WORD_W-1:0]          issue_vk,
  output logic [TAG_W-1:0]           issue_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [WORD_W-1:0]          cdb_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [OP_W-1:0]            disp_op,
  output logic [WORD_W-1:0]          disp_vj,
  output logic [WORD_W-1:0]          disp_vk,
  output logic [TAG_W-1:0]           disp_tag,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  r_busy, r_rj, r_rk;
  logic [OP_W-1:0]   r_op [DEPTH];
  logic [TAG_W-1:0]  r_qj [DEPTH];
  logic [TAG_W-1:0]  r_qk [DEPTH];
  logic [WORD_W-1:0] r_vj [DEPTH];
  logic [WORD_W-1:0] r_vk [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic [DEPTH-1:0]  w_cand, w_pick, w_wake_j, w_wake_k;
  logic [IDX_W-1:0]  w_free_idx, w_sel_idx;
  logic              w_full, w_issue_fire, w_disp_fire, w_cdb_live;
  logic              w_byp_j, w_byp_k, w_ij_rdy, w_ik_rdy;
  logic [WORD_W-1:0] w_ij_val, w_ik_val;

  // Everything visible to issue and dispatch derives from registered state only.
  assign w_cand       = r_busy & r_rj & r_rk;
  assign issue_ready  = !rst && (r_count < CNT_W'(DEPTH));
  assign w_issue_fire = issue_valid && issue_ready;
  assign disp_valid   = |w_cand;
  assign w_disp_fire  = disp_valid && disp_ready;
  assign count        = r_count;
  assign w_cdb_live   = cdb_valid && (cdb_tag != READY_TAG);

  // Same-cycle bypass lets an operand catch a broadcast that coincides with its issue.
  assign w_byp_j  = w_cdb_live && (cdb_tag == issue_qj);
  assign w_byp_k  = w_cdb_live && (cdb_tag == issue_qk);
  assign w_ij_rdy = (issue_qj == READY_TAG) || w_byp_j;
  assign w_ik_rdy = (issue_qk == READY_TAG) || w_byp_k;
  assign w_ij_val = w_byp_j ? cdb_data : issue_vj;
  assign w_ik_val = w_byp_k ? cdb_data : issue_vk;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_free_idx = '0;
    w_full     = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = IDX_W'(i);
        w_full     = 1'b0;
      end
    end
  end

  assign issue_tag = w_full ? '0 : UNIT_BASE + TAG_W'(w_free_idx);

  always_comb begin
    w_wake_j = '0;
    w_wake_k = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wake_j[i] = w_cdb_live && r_busy[i] && !r_rj[i] && (r_qj[i] == cdb_tag);
      w_wake_k[i] = w_cdb_live && r_busy[i] && !r_rk[i] && (r_qk[i] == cdb_tag);
    end
  end

`ifdef RS_AGE_SELECT_EN
  // r_older[i][j] set means entry i was issued before entry j (both busy).
  logic [DEPTH-1:0][DEPTH-1:0] r_older;

  always_comb begin
    w_pick = w_cand;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (w_cand[j] && r_older[j][i]) w_pick[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_older <= '0;
    end else if (flush) begin
      r_older <= '0;
    end else begin
      if (w_issue_fire) begin
        for (int j = 0; j < DEPTH; j++) begin
          r_older[j][w_free_idx] <= r_busy[j];
          r_older[w_free_idx][j] <= 1'b0;
        end
      end
      // Dispatch clearing comes last so it wins over the issue update above.
      if (w_disp_fire) begin
        for (int j = 0; j < DEPTH; j++) begin
          r_older[w_sel_idx][j] <= 1'b0;
          r_older[j][w_sel_idx] <= 1'b0;
        end
      end
    end
  end
`else
  assign w_pick = w_cand;
`endif

  always_comb begin
    w_sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_pick[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign disp_op  = disp_valid ? r_op[w_sel_idx] : '0;
  assign disp_vj  = disp_valid ? r_vj[w_sel_idx] : '0;
  assign disp_vk  = disp_valid ? r_vk[w_sel_idx] : '0;
  assign disp_tag = disp_valid ? UNIT_BASE + TAG_W'(w_sel_idx) : '0;

  // NOTE: sequential state uses non-blocking assignments; later writes in the block take priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_rj    <= '0;
      r_rk    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_rj <= r_rj | w_wake_j;
      r_rk <= r_rk | w_wake_k;
      if (w_disp_fire) r_busy[w_sel_idx] <= 1'b0;
      if (w_issue_fire) begin
        r_busy[w_free_idx] <= 1'b1;
        r_rj[w_free_idx]   <= w_ij_rdy;
        r_rk[w_free_idx]   <= w_ik_rdy;
      end
      r_count <= r_count + CNT_W'(w_issue_fire) - CNT_W'(w_disp_fire);
    end
  end

  // NOTE: payload storage has no reset; it is only observed through busy/ready, which are reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wake_j[i]) r_vj[i] <= cdb_data;
      if (w_wake_k[i]) r_vk[i] <= cdb_data;
    end
    if (w_issue_fire) begin
      r_op[w_free_idx] <= issue_op;
      r_qj[w_free_idx] <= issue_qj;
      r_qk[w_free_idx] <= issue_qk;
      r_vj[w_free_idx] <= w_ij_val;
      r_vk[w_free_idx] <= w_ik_val;
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Randomised and directed bench for rs_station (DEPTH=4) against an entry-list reference model.
module tb_rs_station;

  localparam int         DEPTH     = 4;
  localparam logic [7:0] UNIT_BASE = 8'h20;
  localparam logic [7:0] READY_TAG = 8'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_op;
  logic [7:0]  issue_qj, issue_qk, issue_tag;
  logic [31:0] issue_vj, issue_vk;
  logic        cdb_valid;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_op;
  logic [31:0] disp_vj, disp_vk;
  logic [7:0]  disp_tag;
  logic        flush;
  logic [2:0]  count;

  rs_station #(.DEPTH(DEPTH), .WORD_W(32), .TAG_W(8), .UNIT_BASE(UNIT_BASE),
               .READY_TAG(READY_TAG), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain list of entries, each stamped with its issue sequence number.
  typedef struct {
    bit          busy;
    bit [2:0]    op;
    bit [7:0]    qj, qk;
    bit [31:0]   vj, vk;
    bit          rj, rk;
    int unsigned seq;
  } ent_t;

  ent_t        m [DEPTH];
  int unsigned m_seq;
  int          checks;
  int          failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) n++;
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  // Oldest ready entry with the age feature, otherwise the lowest-index ready entry; -1 if none.
  function automatic int m_sel();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && m[i].rj && m[i].rk) begin
`ifdef RS_AGE_SELECT_EN
        if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
  endtask

  task automatic check_outputs();
    int s = m_sel();
    int f = m_free();
    check("issue_ready", issue_ready, (!rst && m_count() < DEPTH) ? 1 : 0);
    check("issue_tag",   issue_tag,   (f < 0) ? 0 : UNIT_BASE + 8'(f));
    check("count",       count,       m_count());
    check("disp_valid",  disp_valid,  (s >= 0) ? 1 : 0);
    check("disp_op",     disp_op,     (s >= 0) ? m[s].op : 0);
    check("disp_vj",     disp_vj,     (s >= 0) ? m[s].vj : 0);
    check("disp_vk",     disp_vk,     (s >= 0) ? m[s].vk : 0);
    check("disp_tag",    disp_tag,    (s >= 0) ? UNIT_BASE + 8'(s) : 0);
  endtask

  // Apply one clock edge worth of issue / wakeup / dispatch / flush to the model.
  task automatic m_step();
    int  s = m_sel();
    int  f = m_free();
    bit  live = cdb_valid && (cdb_tag != READY_TAG);
    bit  accept = issue_valid && (m_count() < DEPTH);
    if (flush) begin
      m_reset();
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && live && !m[i].rj && m[i].qj == cdb_tag) begin m[i].rj = 1; m[i].vj = cdb_data; end
      if (m[i].busy && live && !m[i].rk && m[i].qk == cdb_tag) begin m[i].rk = 1; m[i].vk = cdb_data; end
    end
    if (s >= 0 && disp_ready) m[s].busy = 1'b0;
    if (accept) begin
      m[f].busy = 1'b1;
      m[f].op   = issue_op;
      m[f].qj   = issue_qj;
      m[f].qk   = issue_qk;
      m[f].seq  = m_seq++;
      if (live && cdb_tag == issue_qj) begin m[f].rj = 1; m[f].vj = cdb_data; end
      else begin m[f].rj = (issue_qj == READY_TAG); m[f].vj = issue_vj; end
      if (live && cdb_tag == issue_qk) begin m[f].rk = 1; m[f].vk = cdb_data; end
      else begin m[f].rk = (issue_qk == READY_TAG); m[f].vk = issue_vk; end
    end
  endtask

  // One cycle, entered and left at a falling edge: drive, check, advance the model, clock.
  task automatic cycle(input bit iv, input bit [2:0] op, input bit [7:0] qj, input bit [31:0] vj,
                       input bit [7:0] qk, input bit [31:0] vk, input bit cv, input bit [7:0] ct,
                       input bit [31:0] cd, input bit dr, input bit fl);
    issue_valid = iv; issue_op = op; issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd; disp_ready = dr; flush = fl;
    #1;
    check_outputs();
    m_step();
    @(negedge clk);
  endtask

  task automatic idle(input bit dr);
    cycle(0, 0, READY_TAG, 0, READY_TAG, 0, 0, 0, 0, dr, 0);
  endtask

  task automatic issue_rdy(input bit [31:0] vj, input bit [31:0] vk, input bit dr);
    cycle(1, 3'd1, READY_TAG, vj, READY_TAG, vk, 0, 0, 0, dr, 0);
  endtask

  function automatic bit [7:0] rand_tag();
    case ($urandom_range(5))
      0, 1:    return READY_TAG;
      2:       return UNIT_BASE + 8'($urandom_range(DEPTH - 1));
      3:       return 8'h41;
      4:       return 8'h42;
      default: return 8'h43;
    endcase
  endfunction

  logic [7:0] age_exp [3];

  initial begin
    checks = 0; failures = 0; m_seq = 0;
    m_reset();
    rst = 1'b1;
    issue_valid = 0; issue_op = 0; issue_qj = 0; issue_vj = 0; issue_qk = 0; issue_vk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; disp_ready = 0; flush = 0;

    // Reset state while held
    repeat (2) @(negedge clk);
    #1;
    check("rst_issue_ready", issue_ready, 0);
    check("rst_count", count, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_tag", disp_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_issue_ready", issue_ready, 1);
    @(negedge clk);

    // Both operands ready at issue
    issue_rdy(5, 7, 0);
    check("tp1_valid", disp_valid, 1);
    check("tp1_vj", disp_vj, 5);
    check("tp1_vk", disp_vk, 7);
    check("tp1_tag", disp_tag, 8'h20);
    idle(1);
    check("tp1_count", count, 0);

    // Operand j waits for CDB tag 41
    cycle(1, 3'd2, 8'h41, 0, READY_TAG, 3, 0, 0, 0, 1, 0);
    check("tp2_wait", disp_valid, 0);
    cycle(0, 0, READY_TAG, 0, READY_TAG, 0, 1, 8'h41, 10, 0, 0);
    check("tp2_valid", disp_valid, 1);
    check("tp2_vj", disp_vj, 10);
    idle(1);

    // Same-cycle bypass
    cycle(1, 3'd3, 8'h41, 0, READY_TAG, 4, 1, 8'h41, 9, 0, 0);
    check("tp3_valid", disp_valid, 1);
    check("tp3_vj", disp_vj, 9);
    idle(1);

    // Fill, then free one slot while issue_valid is held
    for (int i = 0; i < DEPTH; i++) issue_rdy(32'(100 + i), 32'(200 + i), 0);
    check("full_ready", issue_ready, 0);
    check("full_count", count, 4);
    check("full_tag", issue_tag, 0);
    cycle(1, 3'd4, READY_TAG, 55, READY_TAG, 66, 0, 0, 0, 1, 0);
    check("freed_ready", issue_ready, 1);
    check("freed_count", count, 3);
    check("freed_tag", issue_tag, 8'h20);
    cycle(1, 3'd4, READY_TAG, 55, READY_TAG, 66, 0, 0, 0, 0, 0);
    check("refill_count", count, 4);
    repeat (DEPTH) idle(1);

    // Issue order 2, 0, 1
    for (int i = 0; i < 3; i++) issue_rdy(32'(300 + i), 0, 0);
    idle(1);
    idle(1);
    issue_rdy(400, 0, 0);
    issue_rdy(401, 0, 0);
`ifdef RS_AGE_SELECT_EN
    age_exp[0] = 8'h22; age_exp[1] = 8'h20; age_exp[2] = 8'h21;
`else
    age_exp[0] = 8'h20; age_exp[1] = 8'h21; age_exp[2] = 8'h22;
`endif
    for (int i = 0; i < 3; i++) begin
      check("select_order", disp_tag, age_exp[i]);
      idle(1);
    end

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) issue_rdy(32'(500 + i), 1, 0);
    issue_valid = 0; disp_ready = 0;
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", disp_valid, 0);
    check("arst_ready", issue_ready, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Flush beats a coincident issue and dispatch
    issue_rdy(1, 2, 0);
    issue_rdy(3, 4, 0);
    cycle(1, 3'd5, READY_TAG, 9, READY_TAG, 9, 0, 0, 0, 1, 1);
    check("flush_count", count, 0);
    check("flush_valid", disp_valid, 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(2) != 0, 3'($urandom), rand_tag(), $urandom, rand_tag(), $urandom,
            $urandom_range(1) == 1, rand_tag(), $urandom, $urandom_range(1) == 1,
            $urandom_range(39) == 0);
    end
    #1 check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised reservation station for one functional-unit class: the next generation of the fixed 32-entry add/mul/lw stations.
- Accepts issued ops with tagged or ready operands, snoops the common data bus (CDB) to wake up operands, and dispatches one ready op per cycle to its execution unit.
- Dispatch is valid/ready handshaked.
- Sits between the issue logic / register result status and one ALU/MUL/LSU pipe.

Parameters:
- DEPTH, 8, number of entries (2..32).
- WORD_W, 32, operand/result width.
- TAG_W, 8, unit-code width for tags.
- UNIT_BASE, 8'h20, tag of entry 0; entry i owns tag UNIT_BASE+i.
- READY_TAG, 8'h7F, tag value meaning "operand already holds its value".
- OP_W, 3, opcode width carried to the unit.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  issue request
- issue_ready  out  1  station can accept an issue this cycle
- issue_op  in  OP_W  opcode
- issue_qj  in  TAG_W  producer tag of operand j, READY_TAG if value present
- issue_vj  in  WORD_W  operand j value (used when issue_qj==READY_TAG)
- issue_qk  in  TAG_W  producer tag of operand k
- issue_vk  in  WORD_W  operand k value
- issue_tag  out  TAG_W  tag to be allocated (for the register result status write)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcasting unit tag
- cdb_data  in  WORD_W  broadcast result
- disp_valid  out  1  a ready entry is presented
- disp_ready  in  1  unit accepts the op
- disp_op  out  OP_W  opcode of the selected entry
- disp_vj  out  WORD_W  operand j of the selected entry
- disp_vk  out  WORD_W  operand k of the selected entry
- disp_tag  out  TAG_W  tag of the selected entry (unit returns it on the CDB)
- flush  in  1  synchronous clear of all entries
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Entry state: busy, op, qj, vj, rj, qk, vk, rk. Operand is ready (rj/rk) when its q equals READY_TAG or it has been captured from the CDB.
- Reset (async):
  - all busy=0, count=0, disp_valid=0, disp_op/vj/vk/tag=0.
  - issue_ready=0 while rst is high; 1 from the first cycle after release.
- Allocation:
  - issue_tag = UNIT_BASE + lowest-index non-busy entry; 0 when full.
  - issue_ready = !rst && count<DEPTH, computed from registered state only. A slot freed by dispatch in the same cycle is not reusable until the next cycle.
- Issue (issue_valid && issue_ready at posedge):
  - the entry becomes busy; operands load as given.
  - Same-cycle bypass: if cdb_valid and cdb_tag equals issue_qj (or issue_qk) and that tag is not READY_TAG, the operand loads cdb_data and is marked ready.
- Wakeup (posedge, cdb_valid):
  - every busy entry with rj==0 and qj==cdb_tag captures vj=cdb_data and sets rj=1; same rule for k.
  - Both operands may wake in the same cycle.
  - cdb_tag==READY_TAG is ignored.
- Select (combinational from registered state):
  - candidates are busy entries with rj&&rk.
  - disp_valid=1 if any candidate exists; disp_* come from the chosen entry, otherwise all 0.
  - A newly issued entry is eligible no earlier than the cycle after issue (minimum issue-to-dispatch latency 1 cycle).
- Dispatch (disp_valid && disp_ready at posedge): the selected entry clears busy. While disp_ready=0 the selection may change only if a higher-priority entry becomes ready.
- Simultaneous events:
  - issue, CDB wakeup and dispatch in the same cycle all take effect.
  - count updates by +1, -1 or 0 accordingly.
- Flush: clears all busy bits and count the following edge. It has priority over issue, wakeup and dispatch in that cycle.
- Widths: vj/vk are WORD_W, stored unmodified. Tags are compared on all TAG_W bits.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- Defined:
  - a DEPTH x DEPTH age matrix records issue order.
  - Select picks the oldest ready entry.
  - Issuing sets the new entry younger than all busy entries; dispatch and flush clear its row/column.
- Undefined: select picks the lowest-index ready entry; no age state exists.

Test Plan:
- DEPTH=4. Issue add with qj=qk=READY_TAG, vj=5, vk=7 → next cycle disp_valid=1, disp_vj=5, disp_vk=7, disp_tag=8'h20. Dispatch with disp_ready=1 → count returns to 0.
- Issue with qj=8'h41, vk=3 ready → disp_valid stays 0. CDB tag 8'h41, data 10 → next cycle disp_valid=1, disp_vj=10.
- Issue with qj=8'h41 in the same cycle as CDB tag 8'h41, data 9 (bypass) → entry ready; disp_vj=9 the next cycle.
- Issue 4 entries → issue_ready=0, count=4. Dispatch one with issue_valid held → issue_ready=1 only the cycle after; the refilled slot gets tag 8'h20+freed index.
- RS_AGE_SELECT_EN: fill entries 2, 0, 1 in that order, all ready → dispatch order 2, 0, 1. Without the macro → order 0, 1, 2.
- Mid-operation: 3 busy entries, assert rst asynchronously between edges → count=0, disp_valid=0 immediately. Assert flush with issue_valid=1 → count=0 the next cycle and the issue is dropped.
